posit_exec_stage: RTL

Two-stage execute wrapper that sits directly around the team's 8-bit combinational ALU (`posit`). It accepts operations over a valid/ready handshake and registers the operands. It drives the ALU's in1/in2/select ports, then captures the ALU's out/c/z into a result register with a matching valid/ready output. It also holds architectural compare flags and a retired-op counter. The ALU is external; this block feeds it and consumes its result in the same cycle.

---
 rtl/posit_exec_pkg.sv | 26 ++
 rtl/posit_exec_if.sv | 24 ++
 rtl/posit_exec_ctrl.sv | 38 +++
 rtl/posit_exec_stage.sv | 94 +++++++++
 4 files changed

// File: rtl/posit_exec_pkg.sv
// Shared definitions for the posit ALU execute stage: op encodings,
// legality check and compare-result packing.
package posit_exec_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_CMP = 3'b101
  } op_e;

  // AND keeps the ALU's compare outputs quiet while the stage is idle
  localparam logic [2:0] ALU_SEL_RST = OP_AND;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_CMP;
  endfunction

  // Compare result layout in the low bits of out_data: {z, c}
  function automatic logic [1:0] cmp_pack(input logic c, input logic z);
    return {z, c};
  endfunction

endpackage

// File: rtl/posit_exec_if.sv
// Operation-in / result-out handshake bundle for posit_exec_stage.
interface posit_exec_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_err;

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/posit_exec_ctrl.sv
// Valid/ready control for the two-entry execute pipeline (operand and
// result registers); datapath registers live in the top.
module posit_exec_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic accept,
  output logic cap,
  output logic out_fire,
  output logic vld_p2
);

  logic vld_p1;
  logic adv;

  // s1 may move on whenever the result slot is empty or being drained
  assign adv      = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || adv;
  assign accept   = in_valid && in_ready;
  assign cap      = vld_p1 && adv;
  assign out_fire = vld_p2 && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (accept)   vld_p1 <= 1'b1;
      else if (adv) vld_p1 <= 1'b0;

      if (cap)            vld_p2 <= 1'b1;
      else if (out_ready) vld_p2 <= 1'b0;
    end
  end

endmodule

// File: rtl/posit_exec_stage.sv
// Two-stage execute wrapper around the external combinational posit ALU:
// registers operands toward the ALU, captures its result, keeps flags and a retire count.
module posit_exec_stage
  import posit_exec_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  posit_exec_if.slave        bus,
  output logic [DW-1:0]      alu_in1,
  output logic [DW-1:0]      alu_in2,
  output logic [2:0]         alu_select,
  input  logic [DW-1:0]      alu_out,
  input  logic               alu_c,
  input  logic               alu_z,
  output logic               flag_c,
  output logic               flag_z,
  output logic [CNT_W-1:0]   retired
);

  logic          accept;
  logic          cap;
  logic          out_fire;
  logic          vld_p2;
  logic [2:0]    op_p1;
  logic [DW-1:0] res_p2;
  logic          err_p2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  posit_exec_ctrl u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .out_ready (bus.out_ready),
    .in_ready  (bus.in_ready),
    .accept    (accept),
    .cap       (cap),
    .out_fire  (out_fire),
    .vld_p2    (vld_p2)
  );

  assign bus.out_valid = vld_p2;
  assign bus.out_data  = res_p2;
  assign bus.out_err   = err_p2;

  // Stage 1: operand register driving the ALU; illegal ops never reach alu_select
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_select <= ALU_SEL_RST;
      op_p1      <= ALU_SEL_RST;
    end else if (accept) begin
      alu_in1 <= bus.in_a;
      alu_in2 <= bus.in_b;
      op_p1   <= bus.in_op;
      if (op_is_legal(bus.in_op)) alu_select <= bus.in_op;
    end
  end

  // Stage 2: result register and architectural flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_p2 <= '0;
      err_p2 <= 1'b0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (cap) begin
      if (!op_is_legal(op_p1)) begin
        res_p2 <= '0;
        err_p2 <= 1'b1;
      end else if (op_p1 == OP_CMP) begin
        res_p2 <= {{(DW-2){1'b0}}, cmp_pack(alu_c, alu_z)};
        err_p2 <= 1'b0;
        flag_c <= alu_c;
        flag_z <= alu_z;
      end else begin
        res_p2 <= alu_out;
        err_p2 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           retired <= '0;
    else if (out_fire) retired <= sat_inc(retired);
  end

endmodule
